// File: rtl/uart_pkg.sv
// Shared constants for the 16x-oversampled UART receiver: state encoding,
// oversample tick positions and the baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
   } rx_state_t;

   localparam int NB_DATA_DEF = 8;
   localparam int MID_TICK    = 7;
   localparam int FULL_TICK   = 15;
   localparam int OVERSAMPLE  = 16;

   // Nearest-integer clocks per oversample tick.
   function automatic int calc_baud_div(input int clk_hz, input int baud);
      return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle 16x-oversample tick every
// BAUD_DIV clocks.
module uart_baud_tick #(
   parameter int BAUD_DIV    = 163,
   parameter int NB_BAUD_CNT = 8
) (
   input  logic i_clock,
   input  logic i_reset,
   output logic o_s_tick
);

   localparam logic [NB_BAUD_CNT-1:0] CNT_LAST = NB_BAUD_CNT'(BAUD_DIV - 1);

   logic [NB_BAUD_CNT-1:0] cnt_q, cnt_d;
   logic                   tick_q, tick_d;

   // The tick is registered alongside the count so it is high exactly while
   // the count sits at its last value.
   always_comb begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + NB_BAUD_CNT'(1);
      tick_d = (cnt_d == CNT_LAST);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign o_s_tick = tick_q;

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver with 16x oversampling and integrated baud tick.
// Optional stop-bit check enabled by UART_RX_FRAME_ERR_EN (adds o_frame_err).
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low (start edge)
// START | counting to mid start bit, rejects glitches
// DATA  | sampling NB_DATA bits at mid-bit, LSB first
// STOP  | waiting out the stop bit, then publishing the byte
module uart_rx_16x
   import uart_pkg::*;
#(
   parameter int NB_DATA         = NB_DATA_DEF,
   parameter int NB_STATE        = 3,
   parameter int NB_COUNT        = 4,
   parameter int NB_DATA_COUNT   = 4,
   parameter int N_TICKS_TO_STOP = 16,
   parameter int BAUD_DIV        = calc_baud_div(50_000_000, 19_200),
   parameter int NB_BAUD_CNT     = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx,
   output logic               o_s_tick,
   output logic               o_rx_done_tick,
   output logic [NB_DATA-1:0] o_data
`ifdef UART_RX_FRAME_ERR_EN
   ,
   output logic               o_frame_err
`endif
);

   localparam logic [NB_STATE-1:0]      ST_IDLE     = NB_STATE'(IDLE);
   localparam logic [NB_STATE-1:0]      ST_START    = NB_STATE'(START);
   localparam logic [NB_STATE-1:0]      ST_DATA     = NB_STATE'(DATA);
   localparam logic [NB_STATE-1:0]      ST_STOP     = NB_STATE'(STOP);
   localparam logic [NB_COUNT-1:0]      S_MID       = NB_COUNT'(MID_TICK);
   localparam logic [NB_COUNT-1:0]      S_FULL      = NB_COUNT'(FULL_TICK);
   localparam logic [NB_COUNT-1:0]      S_STOP_LAST = NB_COUNT'(N_TICKS_TO_STOP - 1);
   localparam logic [NB_DATA_COUNT-1:0] N_LAST      = NB_DATA_COUNT'(NB_DATA - 1);

   logic                     s_tick;
   logic                     rx_meta_q, rx_s_q;
   logic [NB_STATE-1:0]      state_q, state_d;
   logic [NB_COUNT-1:0]      s_q, s_d;
   logic [NB_DATA_COUNT-1:0] n_q, n_d;
   logic [NB_DATA-1:0]       shift_q, shift_d;
   logic [NB_DATA-1:0]       data_q, data_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;

   uart_baud_tick #(
      .BAUD_DIV    (BAUD_DIV),
      .NB_BAUD_CNT (NB_BAUD_CNT)
   ) u_baud_tick (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .o_s_tick (s_tick)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  s_d = '0;
                  if (!rx_s_q) begin
                     state_d = ST_DATA;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + NB_COUNT'(1);
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (s_q == S_FULL) begin
                  s_d     = '0;
                  shift_d = {rx_s_q, shift_q[NB_DATA-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_d = n_q + NB_DATA_COUNT'(1);
                  end
               end else begin
                  s_d = s_q + NB_COUNT'(1);
               end
            end
         end
         ST_STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP_LAST) begin
                  state_d = ST_IDLE;
                  s_d     = '0;
`ifdef UART_RX_FRAME_ERR_EN
                  // A low stop bit discards the byte and keeps o_data stable.
                  if (!rx_s_q) begin
                     err_d = 1'b1;
                  end else begin
                     data_d = shift_q;
                     done_d = 1'b1;
                  end
`else
                  data_d = shift_q;
                  done_d = 1'b1;
`endif
               end else begin
                  s_d = s_q + NB_COUNT'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            s_d     = '0;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= ST_IDLE;
         s_q       <= '0;
         n_q       <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         s_q       <= s_d;
         n_q       <= n_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign o_s_tick       = s_tick;
   assign o_rx_done_tick = done_q;
   assign o_data         = data_q;

`ifdef UART_RX_FRAME_ERR_EN
   assign o_frame_err = err_q;
`else
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: directed scenarios plus random frames
// against a byte-queue reference model; shortened baud divider keeps runs small.
module tb_uart_rx_16x;

   localparam int BAUD_DIV = 20;
   localparam int BIT_CLKS = 16 * BAUD_DIV;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_rx    = 1'b1;
   logic       o_s_tick;
   logic       o_rx_done_tick;
   logic [7:0] o_data;
`ifdef UART_RX_FRAME_ERR_EN
   logic       o_frame_err;
`endif

   uart_rx_16x #(
      .BAUD_DIV (BAUD_DIV)
   ) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_rx           (i_rx),
      .o_s_tick       (o_s_tick),
      .o_rx_done_tick (o_rx_done_tick),
      .o_data         (o_data)
`ifdef UART_RX_FRAME_ERR_EN
      ,
      .o_frame_err    (o_frame_err)
`endif
   );

   always #10 i_clock = ~i_clock;

   int         checks    = 0;
   int         errors    = 0;
   int         done_seen = 0;
   int         exp_done  = 0;
   int         err_seen  = 0;
   int         err_exp   = 0;
   int         err_pend  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_data = 8'h00;
   logic [7:0] exp_byte;
   logic       prev_done = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: every frame with a good (or unchecked) stop bit yields
   // its byte, in order, and o_data holds it until the next such frame.
   always @(negedge i_clock) begin
      if (o_rx_done_tick) begin
         check_eq("done_width", {31'd0, prev_done}, 32'd0);
         check_eq("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            exp_byte = exp_q.pop_front();
            check_eq("rx_data", {24'd0, o_data}, {24'd0, exp_byte});
            last_data = exp_byte;
         end
         done_seen++;
      end
      prev_done = o_rx_done_tick;
`ifdef UART_RX_FRAME_ERR_EN
      if (o_frame_err) begin
         check_eq("err_expected", {31'd0, err_pend > 0}, 32'd1);
         if (err_pend > 0) err_pend--;
         check_eq("err_data_held", {24'd0, o_data}, {24'd0, last_data});
         err_seen++;
      end
`endif
   end

   task automatic drive_bit(input logic v);
      i_rx = v;
      repeat (BIT_CLKS) @(negedge i_clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input int nstop, input logic stop_val,
                             input bit abort);
      if (!abort) begin
`ifdef UART_RX_FRAME_ERR_EN
         if (stop_val) begin
            exp_q.push_back(b);
            exp_done++;
         end else begin
            err_pend++;
            err_exp++;
         end
`else
         exp_q.push_back(b);
         exp_done++;
`endif
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            check_eq("data_held", {24'd0, o_data}, {24'd0, last_data});
            if (abort) begin
               i_rx = b[4];
               repeat (BIT_CLKS / 2) @(negedge i_clock);
               i_reset = 1'b0;
               i_rx    = 1'b1;
               exp_q.delete();
               last_data = 8'h00;
               repeat (BIT_CLKS) @(negedge i_clock);
               check_eq("abort_data", {24'd0, o_data}, 32'd0);
               check_eq("abort_done", {31'd0, o_rx_done_tick}, 32'd0);
               i_reset = 1'b1;
               repeat (2 * BIT_CLKS) @(negedge i_clock);
               return;
            end
         end
         drive_bit(b[i]);
      end
      if (stop_val) begin
         drive_bit(1'b1);
      end else begin
         // Low only for 3/4 bit so the trailing low is not mistaken for a start.
         i_rx = 1'b0;
         repeat (BIT_CLKS * 3 / 4) @(negedge i_clock);
         i_rx = 1'b1;
         repeat (BIT_CLKS - BIT_CLKS * 3 / 4) @(negedge i_clock);
      end
      for (int k = 1; k < nstop; k++) drive_bit(1'b1);
   endtask

   initial begin
      #(20 * 95000);
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base_done;
      logic [7:0] rb;

      i_reset = 1'b0;
      i_rx    = 1'b1;
      repeat (50) @(negedge i_clock);
      check_eq("rst_data", {24'd0, o_data}, 32'd0);
      check_eq("rst_done", {31'd0, o_rx_done_tick}, 32'd0);
      check_eq("rst_tick", {31'd0, o_s_tick}, 32'd0);
      i_reset = 1'b1;
      @(negedge i_clock);
      k = 1;
      check_eq("rel_data", {24'd0, o_data}, 32'd0);
      check_eq("rel_done", {31'd0, o_rx_done_tick}, 32'd0);
      while (!o_s_tick && k < 4 * BAUD_DIV) begin
         @(negedge i_clock);
         k++;
      end
      check_eq("first_tick", k, BAUD_DIV - 1);
      k = 0;
      do begin
         @(negedge i_clock);
         k++;
      end while (!o_s_tick && k < 4 * BAUD_DIV);
      check_eq("tick_period", k, BAUD_DIV);

      // Single frame with two stop bits, then back-to-back frame.
      send_frame(8'hBD, 2, 1'b1, 1'b0);
      check_eq("bd_count", done_seen, exp_done);
      check_eq("bd_data", {24'd0, o_data}, 32'h0000_00BD);
      send_frame(8'h81, 1, 1'b1, 1'b0);
      repeat (BIT_CLKS) @(negedge i_clock);
      check_eq("b2b_count", done_seen, exp_done);
      check_eq("b2b_data", {24'd0, o_data}, 32'h0000_0081);

      // Glitch: low for 5 ticks only.
      base_done = done_seen;
      i_rx = 1'b0;
      repeat (5 * BAUD_DIV) @(negedge i_clock);
      i_rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge i_clock);
      check_eq("glitch_count", done_seen, base_done);
      check_eq("glitch_data", {24'd0, o_data}, {24'd0, last_data});

      // Reset during data bit 4, then a clean frame.
      base_done = done_seen;
      send_frame(8'hC3, 1, 1'b1, 1'b1);
      check_eq("abort_count", done_seen, base_done);
      send_frame(8'h55, 1, 1'b1, 1'b0);
      repeat (BIT_CLKS) @(negedge i_clock);
      check_eq("post_abort_count", done_seen, exp_done);
      check_eq("post_abort_data", {24'd0, o_data}, 32'h0000_0055);

      // Low stop bit: flagged when the check is built in, accepted otherwise.
      send_frame(8'hA5, 1, 1'b0, 1'b0);
      repeat (2 * BIT_CLKS) @(negedge i_clock);
      check_eq("stop0_count", done_seen, exp_done);
      check_eq("stop0_errs", err_seen, err_exp);
      check_eq("stop0_data", {24'd0, o_data}, {24'd0, last_data});

      for (int f = 0; f < 10; f++) begin
         repeat ($urandom_range(0, BIT_CLKS - 1)) @(negedge i_clock);
         rb = 8'($urandom);
         send_frame(rb, int'($urandom_range(1, 2)), 1'b1, 1'b0);
      end
      repeat (2 * BIT_CLKS) @(negedge i_clock);
      check_eq("rand_count", done_seen, exp_done);
      check_eq("queue_drained", exp_q.size(), 0);
      check_eq("final_data", {24'd0, o_data}, {24'd0, last_data});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
